// File: rtl/unlock_pkg.sv
// Shared definitions for the unlock controller: FSM state encoding, the clear character
// and a width helper used to size counters and indices.
package unlock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_OPEN,
      ST_PROG,
      ST_LOCKOUT
   } state_t;

   localparam logic [7:0] CLR_CHAR = 8'h23;

   // Ceiling log2, never less than 1 so the result can size a vector directly.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/unlock_timer.sv
// Loadable down-counter shared by the open window and the lockout period.
// Counting stops at zero; the zero flag tells the FSM the period has elapsed.
module unlock_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (en && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/unlock_ctrl.sv
// Keypad/ASCII unlock controller: compares fixed-length character attempts against a
// programmable code, opens for a timed window, and locks out after repeated failures.
module unlock_ctrl
   import unlock_pkg::*;
#(
   parameter int                    CODE_LEN       = 4,
   parameter logic [8*CODE_LEN-1:0] DEFAULT_CODE   = "ABCD",
   parameter int                    MAX_FAIL       = 3,
   parameter int                    OPEN_CYCLES    = 50,
   parameter int                    LOCKOUT_CYCLES = 100
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    ascii_in,
   input  logic                          ascii_valid,
   input  logic                          prog_en,
   output logic                          out,
   output logic                          lockout,
   output logic                          err,
   output logic [clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

   localparam int CW = 8 * CODE_LEN;
   localparam int IW = clog2(CODE_LEN);
   localparam int FW = clog2(MAX_FAIL + 1);
   localparam int TW = clog2((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES);

   state_t        state_reg;
   logic [CW-1:0] code_reg;
   logic [CW-1:0] shadow_reg;
   logic [CW-1:0] shadow_next;
   logic [IW-1:0] idx_reg;
   logic          mismatch_reg;

   int            byte_shift;
   logic [7:0]    code_char;
   logic          is_clr;
   logic          last_char;
   logic          attempt_bad;
   logic          eval;
   logic          pass;
   logic          lock_now;
   logic          prog_req;
   logic [FW-1:0] fail_inc;
   logic          tmr_load;
   logic          tmr_en;
   logic          tmr_zero;
   logic [TW-1:0] tmr_load_val;

   // Character idx lives in byte (CODE_LEN-1-idx): the first character is the MSB byte.
   always_comb begin
      byte_shift   = 8 * (CODE_LEN - 1 - int'(idx_reg));
      code_char    = 8'(code_reg >> byte_shift);
      shadow_next  = (shadow_reg & ~(CW'(8'hFF) << byte_shift)) | (CW'(ascii_in) << byte_shift);
      is_clr       = (ascii_in == CLR_CHAR);
      last_char    = (idx_reg == IW'(CODE_LEN - 1));
      attempt_bad  = mismatch_reg | (ascii_in != code_char);
      eval         = ascii_valid && !is_clr && last_char &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_ENTRY));
      pass         = eval && !attempt_bad;
      fail_inc     = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + FW'(1);
      lock_now     = eval && attempt_bad && (fail_inc == FW'(MAX_FAIL));
      prog_req     = (state_reg == ST_OPEN) && ascii_valid && prog_en && !is_clr;
      tmr_load     = pass || lock_now;
      tmr_load_val = pass ? TW'(OPEN_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
      tmr_en       = (state_reg == ST_OPEN) || (state_reg == ST_LOCKOUT);
   end

   unlock_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         code_reg     <= DEFAULT_CODE;
         shadow_reg   <= '0;
         idx_reg      <= '0;
         mismatch_reg <= 1'b0;
         out          <= 1'b0;
         lockout      <= 1'b0;
         err          <= 1'b0;
         fail_cnt     <= '0;
      end else begin
         err <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_ENTRY: begin
               if (ascii_valid && is_clr) begin
                  state_reg    <= ST_IDLE;
                  idx_reg      <= '0;
                  mismatch_reg <= 1'b0;
               end else if (ascii_valid && last_char) begin
                  idx_reg      <= '0;
                  mismatch_reg <= 1'b0;
                  if (!attempt_bad) begin
                     state_reg <= ST_OPEN;
                     out       <= 1'b1;
                     fail_cnt  <= '0;
                  end else begin
                     err      <= 1'b1;
                     fail_cnt <= fail_inc;
                     if (lock_now) begin
                        state_reg <= ST_LOCKOUT;
                        lockout   <= 1'b1;
                     end else begin
                        state_reg <= ST_IDLE;
                     end
                  end
               end else if (ascii_valid) begin
                  state_reg    <= ST_ENTRY;
                  idx_reg      <= idx_reg + IW'(1);
                  mismatch_reg <= attempt_bad;
               end
            end
            ST_OPEN: begin
               // A programming request wins over the window expiring on the same cycle.
               if (prog_req) begin
                  out        <= 1'b0;
                  shadow_reg <= shadow_next;
                  if (CODE_LEN == 1) begin
                     code_reg  <= shadow_next;
                     state_reg <= ST_IDLE;
                  end else begin
                     state_reg <= ST_PROG;
                     idx_reg   <= IW'(1);
                  end
               end else if (tmr_zero) begin
                  out       <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            ST_PROG: begin
               if (ascii_valid && is_clr) begin
                  state_reg <= ST_IDLE;
                  idx_reg   <= '0;
               end else if (ascii_valid) begin
                  shadow_reg <= shadow_next;
                  if (last_char) begin
                     code_reg  <= shadow_next;
                     state_reg <= ST_IDLE;
                     idx_reg   <= '0;
                  end else begin
                     idx_reg <= idx_reg + IW'(1);
                  end
               end
            end
            ST_LOCKOUT: begin
               if (tmr_zero) begin
                  state_reg <= ST_IDLE;
                  lockout   <= 1'b0;
                  fail_cnt  <= '0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               idx_reg   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unlock_ctrl.sv
// Scoreboard bench for unlock_ctrl: a character-level reference model predicts output
// change events; a negedge monitor pops and compares them against the DUT.
module tb_unlock_ctrl;

   localparam int  CODE_LEN = 4;
   localparam int  MAX_FAIL = 3;
   localparam int  OPEN_CYC = 10;
   localparam int  LOCK_CYC = 20;
   localparam byte CLR      = 8'h23;

   logic       clk         = 1'b0;
   logic       reset       = 1'b0;
   logic [7:0] ascii_in    = 8'h00;
   logic       ascii_valid = 1'b0;
   logic       prog_en     = 1'b0;
   logic       out;
   logic       lockout;
   logic       err;
   logic [1:0] fail_cnt;

   unlock_ctrl #(
      .CODE_LEN       (CODE_LEN),
      .DEFAULT_CODE   ("ABCD"),
      .MAX_FAIL       (MAX_FAIL),
      .OPEN_CYCLES    (OPEN_CYC),
      .LOCKOUT_CYCLES (LOCK_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ascii_in    (ascii_in),
      .ascii_valid (ascii_valid),
      .prog_en     (prog_en),
      .out         (out),
      .lockout     (lockout),
      .err         (err),
      .fail_cnt    (fail_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [4:0] v;   // {out, lockout, err, fail_cnt}
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;

   // Reference model: attempt buffer, programming buffer and remaining-cycle counts.
   byte        m_code[CODE_LEN];
   byte        m_entry[$];
   byte        m_prog[$];
   bit         m_in_prog;
   int         m_open;
   int         m_lock;
   int         m_fails;
   bit         m_err;
   logic [4:0] m_prev;

   task automatic m_reset();
      string dflt;
      dflt = "ABCD";
      for (int i = 0; i < CODE_LEN; i++) m_code[i] = dflt[i];
      m_entry.delete();
      m_prog.delete();
      m_in_prog = 1'b0;
      m_open    = 0;
      m_lock    = 0;
      m_fails   = 0;
      m_err     = 1'b0;
      m_prev    = '0;
   endtask

   task automatic m_step(input bit v, input byte c, input bit p);
      logic [4:0] nv;
      exp_t       e;
      bit         ok;
      m_err = 1'b0;
      if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_fails = 0;
      end else if (m_open > 0) begin
         if (v && p && c != CLR) begin
            m_open = 0;
            m_prog.delete();
            m_prog.push_back(c);
            m_in_prog = 1'b1;
         end else begin
            m_open--;
         end
      end else if (m_in_prog) begin
         if (v && c == CLR) begin
            m_in_prog = 1'b0;
         end else if (v) begin
            m_prog.push_back(c);
            if (m_prog.size() == CODE_LEN) begin
               for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_prog[i];
               m_in_prog = 1'b0;
            end
         end
      end else if (v) begin
         if (c == CLR) begin
            m_entry.delete();
         end else begin
            m_entry.push_back(c);
            if (m_entry.size() == CODE_LEN) begin
               ok = 1'b1;
               for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
               m_entry.delete();
               if (ok) begin
                  m_open  = OPEN_CYC;
                  m_fails = 0;
               end else begin
                  m_err = 1'b1;
                  if (m_fails < MAX_FAIL) m_fails++;
                  if (m_fails == MAX_FAIL) m_lock = LOCK_CYC;
               end
            end
         end
      end
      nv = {(m_open > 0), (m_lock > 0), m_err, 2'(m_fails)};
      if (nv != m_prev || m_err) begin
         e.cyc = cyc;
         e.v   = nv;
         exp_q.push_back(e);
      end
      m_prev = nv;
   endtask

   // Monitor: any change of the output vector (or an err pulse) is a DUT transaction.
   logic [4:0] mon_prev = '0;
   logic [4:0] mon_dv;
   exp_t       mon_e;
   always @(negedge clk) begin
      if (!mon_en) begin
         mon_prev = '0;
      end else begin
         mon_dv = {out, lockout, err, fail_cnt};
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event cyc=%0d got=none want=%b@%0d", cyc, mon_e.v, mon_e.cyc);
         end
         if (mon_dv !== mon_prev || err !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, mon_dv);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.cyc != cyc || mon_e.v !== mon_dv) begin
                  n_bad++;
                  $display("FAIL event cyc=%0d got=%b want=%b@%0d", cyc, mon_dv, mon_e.v, mon_e.cyc);
               end else begin
                  $display("[cyc %0d] out=%b lockout=%b err=%b fail_cnt=%0d ok",
                           cyc, out, lockout, err, fail_cnt);
               end
            end
            mon_prev = mon_dv;
         end
      end
   end

   task automatic step(input bit v, input byte c, input bit p);
      ascii_valid = v;
      ascii_in    = c;
      prog_en     = p;
      @(posedge clk);
      #1;
      m_step(v, c, p);
      ascii_valid = 1'b0;
      prog_en     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send_str(input string s, input bit prog_first);
      for (int i = 0; i < s.len(); i++) step(1'b1, s[i], prog_first && (i == 0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_at_reset got=%0d want=0", exp_q.size());
      end
      exp_q.delete();
      ascii_valid = 1'b0;
      prog_en     = 1'b0;
      reset       = 1'b0;
      #1;
      n_cmp++;
      if ({out, lockout, err, fail_cnt} !== 5'b0) begin
         n_bad++;
         $display("FAIL async_reset got=%b want=00000", {out, lockout, err, fail_cnt});
      end else begin
         $display("[t=%0t] async reset: outputs cleared", $time);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_reset();
      @(posedge clk);
      #1;
      mon_en = 1'b1;
   endtask

   initial begin
      string alpha;
      int    kind;
      int    gap;
      alpha = "ABCDWXYZ#";
      m_reset();
      #50;
      n_cmp++;
      if ({out, lockout, err, fail_cnt} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_state got=%b want=00000", {out, lockout, err, fail_cnt});
      end else begin
         $display("[t=%0t] reset state: outputs 0", $time);
      end
      #50;
      reset = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Correct code opens for the window.
      send_str("ABCD", 1'b0);  idle(15);
      // A wrong attempt consumes exactly four characters.
      send_str("ABCABCD", 1'b0); idle(2); send_str("ABCD", 1'b0); idle(12);
      // Three failures lock out; the code is ignored during lockout.
      send_str("XXXX", 1'b0); send_str("XXXX", 1'b0); send_str("XXXX", 1'b0);
      send_str("ABCD", 1'b0); idle(25); send_str("ABCD", 1'b0); idle(12);
      // Clear discards a partial attempt without counting it.
      send_str("AB#ABCD", 1'b0); idle(12);
      // Reprogram to WXYZ, then an aborted reprogram leaves WXYZ in place.
      send_str("ABCD", 1'b0); idle(2); send_str("WXYZ", 1'b1); idle(2);
      send_str("ABCD", 1'b0); idle(2); send_str("WXYZ", 1'b0); idle(2);
      send_str("WX#", 1'b1); idle(2); send_str("WXYZ", 1'b0); idle(12);
      // Reset during PROG and during LOCKOUT restores the default code.
      send_str("WXYZ", 1'b0); idle(1); send_str("WX", 1'b1);
      do_reset();
      send_str("ABCD", 1'b0); idle(12);
      send_str("QQQQ", 1'b0); send_str("QQQQ", 1'b0); send_str("QQQQ", 1'b0); idle(5);
      do_reset();
      send_str("ABCD", 1'b0); idle(12);

      // Randomized bursts; type 0 replays the model's current code to reach OPEN/PROG.
      for (int b = 0; b < 250; b++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: for (int i = 0; i < CODE_LEN; i++) step(1'b1, m_code[i], ($urandom_range(0, 7) == 0));
            1: for (int i = 0; i < CODE_LEN; i++) step(1'b1, alpha[$urandom_range(0, 7)], ($urandom_range(0, 7) == 0));
            2: for (int i = 0; i < CODE_LEN; i++) step(($urandom_range(0, 3) != 0), alpha[$urandom_range(0, 8)], ($urandom_range(0, 3) == 0));
            default: begin
               step(1'b1, alpha[$urandom_range(0, 7)], 1'b1);
               for (int i = 1; i < CODE_LEN; i++) step(1'b1, alpha[$urandom_range(0, 8)], 1'b0);
            end
         endcase
         gap = $urandom_range(0, 3);
         idle(gap);
      end
      idle(30);

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_events got=%0d want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
